// File: rtl/stoch_bitstream_decode.sv
// stoch_bitstream_decode: counts 1s over 2^WINDOW_BITS accepted stochastic samples and hands the count out under valid/ready
module stoch_bitstream_decode #(
  parameter int WINDOW_BITS = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 start,
  input  logic                 cont,
  input  logic                 bit_in,
  input  logic                 in_valid,
  output logic                 busy,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WINDOW_BITS:0] result
);
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
  state_t state, state_nxt;
  logic [WINDOW_BITS-1:0] sample_cnt;
  logic [WINDOW_BITS:0] ones_cnt, ones_sum;
  logic take, last, clr;
  assign ones_sum = ones_cnt + (WINDOW_BITS+1)'(bit_in);
  // an abort (start in ACCUM) discards the sample and outranks completion
  assign take = state == ACCUM && !start && in_valid;
  assign last = take && &sample_cnt;
  assign clr = (state != DONE && start) || (state == DONE && out_ready);
  assign busy = state == ACCUM;
  assign out_valid = state == DONE;
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    state_nxt = start ? ACCUM : IDLE;
      ACCUM:   state_nxt = last ? DONE : ACCUM;
      DONE:    state_nxt = out_ready ? (cont ? ACCUM : IDLE) : DONE;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else state <= state_nxt;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      sample_cnt <= '0;
      ones_cnt <= '0;
      result <= '0;
    end else begin
      if (clr) begin
        sample_cnt <= '0;
        ones_cnt <= '0;
      end else if (take) begin
        sample_cnt <= sample_cnt + WINDOW_BITS'(1);
        ones_cnt <= ones_sum;
      end
      if (last) result <= ones_sum;
    end
  end
endmodule

// File: doc/stoch_bitstream_decode.md
Name: stoch_bitstream_decode

Overview:
- Downstream stage for the stochastic arithmetic units, such as the saturating subtractor: converts a unipolar stochastic bitstream back to a binary value.
- Counts the 1s over a fixed window of 2^WINDOW_BITS accepted samples, then presents the count under a valid/ready handshake.
- Supports one-shot and continuous (back-to-back window) operation.
- Used at the boundary between stochastic datapaths and deterministic control/readout logic.

Parameters:
- WINDOW_BITS, 8, log2 of the window length in accepted samples (window = 2^WINDOW_BITS); legal range 2..16.

Ports:
- CLK  input  1  clock; all logic on posedge.
- RST  input  1  synchronous, active-high reset.
- start  input  1  single-cycle request to begin a window.
- cont  input  1  continuous mode; sampled at each output handshake.
- bit_in  input  1  stochastic bitstream sample.
- in_valid  input  1  bit_in is a real sample this cycle.
- busy  output  1  high in ACCUM.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- result  output  WINDOW_BITS+1  count of 1s in the window, 0..2^WINDOW_BITS.

Behaviour:
- Reset (RST=1 at posedge), from any state including mid-window:
  - state=IDLE; busy=0, out_valid=0, result=0.
  - Internal ones counter and sample counter = 0.
- Registers: state (IDLE/ACCUM/DONE), sample_cnt (WINDOW_BITS bits), ones_cnt (WINDOW_BITS+1 bits), result register. All outputs are registered or decoded from state only; there is no combinational path from inputs to outputs.
- IDLE:
  - in_valid/bit_in ignored.
  - start=1 -> ACCUM next cycle, with sample_cnt=0 and ones_cnt=0.
  - The sample present in the start cycle is NOT counted.
- ACCUM:
  - Each cycle with in_valid=1: ones_cnt += bit_in and sample_cnt += 1 (sample_cnt wraps to 0).
  - Cycles with in_valid=0 leave both counters unchanged; gaps stretch the window in time, not in samples.
  - When in_valid=1 and sample_cnt == 2^WINDOW_BITS-1 (last sample):
    - result <= ones_cnt + bit_in; -> DONE.
    - out_valid=1 the cycle after the last accepted sample (latency 1).
  - start=1 in ACCUM aborts the window:
    - Counters cleared, stays in ACCUM; the sample in that cycle is discarded.
    - Abort takes priority over last-sample completion in the same cycle.
- DONE:
  - out_valid=1; result held stable until the handshake.
  - in_valid samples dropped; start ignored.
  - Handshake = out_valid & out_ready at posedge:
    - cont=1 -> ACCUM with counters cleared; the first countable sample is in the next cycle.
    - cont=0 -> IDLE.
    - out_valid deasserts the cycle after the handshake.
- result keeps its last value after the handshake until the next window completes; it is only meaningful while out_valid=1.
- Arithmetic: ones_cnt cannot overflow (max 2^WINDOW_BITS fits in WINDOW_BITS+1 bits). No saturation or rounding. The consumer interprets the value as result / 2^WINDOW_BITS.
- RST has priority over start, handshake and sample acceptance.

Test Plan:
- WINDOW_BITS=4; start, then 16 consecutive in_valid=1 with bit_in=1, out_ready=1 -> out_valid one cycle after the 16th sample, result=16, back to IDLE, busy=0.
- Alternating bit_in 1/0 for 16 samples with in_valid deasserted on every third cycle -> result=8; window completes only after the 16th accepted sample; gap cycles are not counted.
- All-zero window, out_ready held low for 10 cycles -> out_valid and result=0 held stable for all 10 cycles; bits driven during DONE do not affect the next window.
- cont=1 with three windows of 4, 12 and 16 ones (out_ready=1) -> three results 4, 12, 16; each new window starts the cycle after its handshake.
- start pulsed after 7 accepted samples -> counters cleared; the next 16 samples (all 1s) give result=16. Also: RST asserted mid-window and in DONE -> out_valid=0, result=0, busy=0 next cycle.
- Same-cycle start and last sample -> abort wins, no out_valid; in DONE, start is ignored.
